count_day: RTL and testbench

BCD day-of-month counter for the century clock, directly upstream of the month counter. It advances on the day-carry from the hour stage. It wraps at the month length decoded from the month counter's `mon_31` / `mon_30` / `mon_29` flags and the year stage's leap flag. It emits the month-enable carry `en_mo` in the same cycle as the wrap, so both counters update on one edge. It also supports manual up/down setting and clamps the day when a month change makes it invalid.

---
 rtl/century_clock_pkg.sv | 19 +
 rtl/count_day_limit.sv | 53 +++++
 rtl/count_day.sv | 133 +++++++++++++
 tb/tb_count_day.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/century_clock_pkg.sv
// Shared constants for the century clock counters.
// Day values are packed BCD: tens in [7:4], units in [3:0].
package century_clock_pkg;

   localparam logic [7:0] DAY_MAX_31 = 8'h31;
   localparam logic [7:0] DAY_MAX_30 = 8'h30;
   localparam logic [7:0] DAY_MAX_29 = 8'h29;
   localparam logic [7:0] DAY_MAX_28 = 8'h28;
   localparam logic [7:0] DAY_FIRST  = 8'h01;

   function automatic logic [3:0] bcd_ten(input logic [7:0] d);
      return d[7:4];
   endfunction

   function automatic logic [3:0] bcd_unit(input logic [7:0] d);
      return d[3:0];
   endfunction

endpackage

// File: rtl/count_day_limit.sv
// Month length decode and BCD day-vs-limit compare.
// Macro COUNT_DAY_LEAP_EN: February is 28 days unless i_leap is set.
module day_limit
   import century_clock_pkg::*;
#(
   parameter int MAX_DISPLAY_UNIT = 4,
   parameter int MAX_DISPLAY_TEN  = 2
) (
   input  logic [MAX_DISPLAY_TEN-1:0]  i_day_ten,
   input  logic [MAX_DISPLAY_UNIT-1:0] i_day_unit,
   input  logic                        i_mon_30,
   input  logic                        i_mon_29,
   input  logic                        i_leap,
   output logic [MAX_DISPLAY_TEN-1:0]  o_max_ten,
   output logic [MAX_DISPLAY_UNIT-1:0] o_max_unit,
   output logic                        o_at_max,
   output logic                        o_over_max
);

   logic [7:0] w_feb;
   logic [7:0] w_max;

`ifdef COUNT_DAY_LEAP_EN
   assign w_feb = i_leap ? DAY_MAX_29 : DAY_MAX_28;
`else
   logic w_unused_leap;
   assign w_unused_leap = i_leap;
   assign w_feb = DAY_MAX_29;
`endif

   // February wins over 30-day months; anything else reads as 31
   always_comb begin
      w_max = DAY_MAX_31;
      if (i_mon_29)
         w_max = w_feb;
      else if (i_mon_30)
         w_max = DAY_MAX_30;
   end

   assign o_max_ten  = MAX_DISPLAY_TEN'(bcd_ten(w_max));
   assign o_max_unit = MAX_DISPLAY_UNIT'(bcd_unit(w_max));

   // BCD compare: tens first, then units
   always_comb begin
      o_at_max   = (i_day_ten > o_max_ten) |
                   ((i_day_ten == o_max_ten) &
                    (i_day_unit >= o_max_unit));
      o_over_max = (i_day_ten > o_max_ten) |
                   ((i_day_ten == o_max_ten) &
                    (i_day_unit > o_max_unit));
   end

endmodule

// File: rtl/count_day.sv
// BCD day-of-month counter with month carry and clamp.
// Macro COUNT_DAY_LEAP_EN enables 28-day February in non-leap years.
module count_day
   import century_clock_pkg::*;
#(
   parameter int MAX_DISPLAY_UNIT = 4,
   parameter int MAX_DISPLAY_TEN  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en_d,
   input  logic                        preset,
   input  logic                        up,
   input  logic                        down,
   input  logic                        mon_31,
   input  logic                        mon_30,
   input  logic                        mon_29,
   input  logic                        leap,
   output logic [MAX_DISPLAY_UNIT-1:0] day_unit,
   output logic [MAX_DISPLAY_TEN-1:0]  day_ten,
   output logic                        en_mo
);

   localparam logic [MAX_DISPLAY_TEN-1:0] L_FIRST_TEN =
      MAX_DISPLAY_TEN'(bcd_ten(DAY_FIRST));
   localparam logic [MAX_DISPLAY_UNIT-1:0] L_FIRST_UNIT =
      MAX_DISPLAY_UNIT'(bcd_unit(DAY_FIRST));
   localparam logic [MAX_DISPLAY_UNIT-1:0] L_NINE =
      MAX_DISPLAY_UNIT'(9);
   localparam logic [MAX_DISPLAY_UNIT-1:0] L_U1 =
      MAX_DISPLAY_UNIT'(1);
   localparam logic [MAX_DISPLAY_TEN-1:0] L_T1 =
      MAX_DISPLAY_TEN'(1);

   logic [MAX_DISPLAY_TEN-1:0]  r_day_ten;
   logic [MAX_DISPLAY_UNIT-1:0] r_day_unit;
   logic [MAX_DISPLAY_TEN-1:0]  w_nxt_ten;
   logic [MAX_DISPLAY_UNIT-1:0] w_nxt_unit;
   logic [MAX_DISPLAY_TEN-1:0]  w_max_ten;
   logic [MAX_DISPLAY_UNIT-1:0] w_max_unit;
   logic [MAX_DISPLAY_TEN-1:0]  w_inc_ten;
   logic [MAX_DISPLAY_UNIT-1:0] w_inc_unit;
   logic [MAX_DISPLAY_TEN-1:0]  w_dec_ten;
   logic [MAX_DISPLAY_UNIT-1:0] w_dec_unit;
   logic                        w_at_max;
   logic                        w_over_max;
   logic                        w_is_first;
   logic                        w_unused;

   // Length is decoded from mon_29/mon_30 alone; 31 is the fallback
   assign w_unused = mon_31;

   day_limit #(
      .MAX_DISPLAY_UNIT (MAX_DISPLAY_UNIT),
      .MAX_DISPLAY_TEN  (MAX_DISPLAY_TEN)
   ) u_limit (
      .i_day_ten  (r_day_ten),
      .i_day_unit (r_day_unit),
      .i_mon_30   (mon_30),
      .i_mon_29   (mon_29),
      .i_leap     (leap),
      .o_max_ten  (w_max_ten),
      .o_max_unit (w_max_unit),
      .o_at_max   (w_at_max),
      .o_over_max (w_over_max)
   );

   assign w_is_first = (r_day_ten == L_FIRST_TEN) &
                       (r_day_unit == L_FIRST_UNIT);

   // BCD +1 and -1 of the current day
   always_comb begin
      w_inc_ten  = r_day_ten;
      w_inc_unit = r_day_unit + L_U1;
      if (r_day_unit == L_NINE) begin
         w_inc_ten  = r_day_ten + L_T1;
         w_inc_unit = '0;
      end
      w_dec_ten  = r_day_ten;
      w_dec_unit = r_day_unit - L_U1;
      if (r_day_unit == '0) begin
         w_dec_ten  = r_day_ten - L_T1;
         w_dec_unit = L_NINE;
      end
   end

   // Next day: preset, carry, manual up/down, then clamp or hold
   always_comb begin
      w_nxt_ten  = r_day_ten;
      w_nxt_unit = r_day_unit;
      if (preset) begin
         w_nxt_ten  = L_FIRST_TEN;
         w_nxt_unit = L_FIRST_UNIT;
      end else if (en_d || (up && !down)) begin
         if (w_at_max) begin
            w_nxt_ten  = L_FIRST_TEN;
            w_nxt_unit = L_FIRST_UNIT;
         end else begin
            w_nxt_ten  = w_inc_ten;
            w_nxt_unit = w_inc_unit;
         end
      end else if (down && !up) begin
         if (w_is_first || w_over_max) begin
            w_nxt_ten  = w_max_ten;
            w_nxt_unit = w_max_unit;
         end else begin
            w_nxt_ten  = w_dec_ten;
            w_nxt_unit = w_dec_unit;
         end
      end else if (w_over_max) begin
         w_nxt_ten  = w_max_ten;
         w_nxt_unit = w_max_unit;
      end
   end

   // Day register, reset to the first of the month
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_day_ten  <= L_FIRST_TEN;
         r_day_unit <= L_FIRST_UNIT;
      end else begin
         r_day_ten  <= w_nxt_ten;
         r_day_unit <= w_nxt_unit;
      end
   end

   assign day_ten  = r_day_ten;
   assign day_unit = r_day_unit;

   // Month carry only for the hour-driven wrap, never for manual setting
   assign en_mo = en_d & ~preset & w_at_max;

endmodule

// File: tb/tb_count_day.sv
// Directed bench for count_day with a queue-based scoreboard.
// Build with or without COUNT_DAY_LEAP_EN to match the RTL.
module tb_count_day;

   typedef struct packed {
      logic [7:0] day;
      logic       mo;
   } exp_t;

   localparam logic [3:0] M31 = 4'b1000;
   localparam logic [3:0] M30 = 4'b0100;
   localparam logic [3:0] F0  = 4'b0010;
   localparam logic [3:0] F1  = 4'b0011;
`ifdef COUNT_DAY_LEAP_EN
   localparam logic [7:0] FEB0 = 8'h28;
`else
   localparam logic [7:0] FEB0 = 8'h29;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en_d = 1'b0;
   logic       preset = 1'b0;
   logic       up = 1'b0;
   logic       down = 1'b0;
   logic       mon_31 = 1'b1;
   logic       mon_30 = 1'b0;
   logic       mon_29 = 1'b0;
   logic       leap = 1'b0;
   logic [3:0] day_unit;
   logic [1:0] day_ten;
   logic       en_mo;

   exp_t       q[$];
   exp_t       e_cur;
   logic [7:0] act;
   int         n_pass = 0;
   int         n_total = 0;
   int         n_step = 0;

   count_day dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_d     (en_d),
      .preset   (preset),
      .up       (up),
      .down     (down),
      .mon_31   (mon_31),
      .mon_30   (mon_30),
      .mon_29   (mon_29),
      .leap     (leap),
      .day_unit (day_unit),
      .day_ten  (day_ten),
      .en_mo    (en_mo)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   // Apply one cycle of inputs; expect the day held this cycle
   // and the combinational carry for these inputs.
   task automatic cyc(input logic [3:0] fl,
                      input logic ed, input logic pr,
                      input logic u, input logic dn,
                      input logic [7:0] xd, input logic xm);
      @(posedge clk);
      #2;
      {mon_31, mon_30, mon_29, leap} = fl;
      en_d   = ed;
      preset = pr;
      up     = u;
      down   = dn;
      q.push_back({xd, xm});
   endtask

   // Monitor: compare presented outputs against the queue head
   always @(negedge clk) begin
      if (q.size() != 0) begin
         e_cur = q.pop_front();
         act   = {2'b00, day_ten, day_unit};
         n_total++;
         n_step++;
         if (act === e_cur.day && en_mo === e_cur.mo)
            n_pass++;
         else
            $display("FAIL step%0d: day=%h en_mo=%b, want day=%h en_mo=%b",
                     n_step, act, en_mo, e_cur.day, e_cur.mo);
      end
   end

   initial begin
      // reset state
      cyc(M31, 0, 0, 0, 0, 8'h01, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // 30 carries through a 31-day month, then the wrap
      for (int i = 1; i <= 30; i++)
         cyc(M31, 1, 0, 0, 0, bcd(i), 0);
      cyc(M31, 1, 0, 0, 0, 8'h31, 1);
      cyc(M31, 0, 0, 0, 0, 8'h01, 0);

      // 30-day month: carry wrap and manual wrap
      cyc(M30, 0, 0, 0, 1, 8'h01, 0);
      cyc(M30, 1, 0, 0, 0, 8'h30, 1);
      cyc(M30, 0, 0, 0, 1, 8'h01, 0);
      cyc(M30, 0, 0, 1, 0, 8'h30, 0);
      cyc(M30, 0, 0, 0, 0, 8'h01, 0);

      // February, leap year
      cyc(F1, 0, 0, 0, 1, 8'h01, 0);
      cyc(F1, 0, 0, 0, 1, 8'h29, 0);
      cyc(F1, 1, 0, 0, 0, 8'h28, 0);
      cyc(F1, 1, 0, 0, 0, 8'h29, 1);
      cyc(F1, 0, 0, 0, 0, 8'h01, 0);

      // February, non-leap year
`ifdef COUNT_DAY_LEAP_EN
      cyc(F0, 0, 0, 0, 1, 8'h01, 0);
      cyc(F0, 1, 0, 0, 0, 8'h28, 1);
      cyc(F0, 0, 0, 0, 0, 8'h01, 0);
`else
      cyc(F0, 0, 0, 0, 1, 8'h01, 0);
      cyc(F0, 0, 0, 0, 1, 8'h29, 0);
      cyc(F0, 1, 0, 0, 0, 8'h28, 0);
      cyc(F0, 1, 0, 0, 0, 8'h29, 1);
      cyc(F0, 0, 0, 0, 0, 8'h01, 0);
`endif

      // clamp when the month shrinks
      cyc(M31, 0, 0, 0, 1, 8'h01, 0);
      cyc(M30, 0, 0, 0, 0, 8'h31, 0);
      cyc(F0, 0, 0, 0, 0, 8'h30, 0);
      cyc(F0, 0, 0, 0, 0, FEB0, 0);

      // preset, down wrap, up+down hold, en_d+preset
      cyc(M31, 0, 1, 0, 0, FEB0, 0);
      cyc(M31, 0, 0, 0, 1, 8'h01, 0);
      cyc(M31, 0, 0, 1, 1, 8'h31, 0);
      cyc(M31, 1, 1, 0, 0, 8'h31, 0);
      cyc(M31, 0, 0, 0, 0, 8'h01, 0);

      // BCD carry and borrow across 09/10, en_d beats down
      for (int i = 1; i <= 9; i++)
         cyc(M31, 0, 0, 1, 0, bcd(i), 0);
      cyc(M31, 0, 0, 0, 1, 8'h10, 0);
      cyc(M31, 1, 0, 0, 1, 8'h09, 0);
      cyc(M31, 0, 0, 0, 0, 8'h10, 0);

      // asynchronous reset mid-operation
      @(negedge clk);
      #1 rst_n = 1'b0;
      cyc(M31, 0, 0, 0, 0, 8'h01, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      cyc(M31, 0, 0, 0, 0, 8'h01, 0);

      for (int k = 0; k < 10 && q.size() != 0; k++)
         @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_total++;
         $display("FAIL drain: pending=%0d, want 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
